// File: rtl/pipe_sched.sv
// Purpose : RV32I hazard scheduler; scoreboard of pending rd writes + RUN/DSTALL/CWAIT FSM.
// Latency : stall/bubble/flush/issue are combinational; state and busy_vec update on the next edge.
// Backpr. : RAW hazard holds PC and IF/ID and bubbles ID/EX; a control op holds until the branch resolves.
// Ports   : clk, rst_n (sync, active-low); inst_id/id_valid from IF/ID; wb_we/wb_rd from WB;
//           br_done/br_taken from EX; stall_if, bubble_ex, flush_id, issue, state, busy_vec out.
// Option  : PIPE_SCHED_PERF_EN adds stall_data_cnt / stall_ctrl_cnt performance counters.
module pipe_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_id,
    input  logic        id_valid,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic        br_done,
    input  logic        br_taken,
    output logic        stall_if,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic        issue,
    output logic [1:0]  state,
`ifdef PIPE_SCHED_PERF_EN
    output logic [31:0] stall_data_cnt,
    output logic [31:0] stall_ctrl_cnt,
`endif
    output logic [31:0] busy_vec
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DSTALL = 2'd1,
        ST_CWAIT  = 2'd2
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    state_t      state_q, state_d;
    logic [31:0] busy_q, busy_d;
    logic [31:0] busy_eff;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       use_rs1, use_rs2, writes_rd, ctrl, data_hazard;

    // funct3/funct7 do not influence scheduling
    logic unused_funct;
    assign unused_funct = ^{inst_id[31:25], inst_id[14:12]};

    assign opcode = inst_id[6:0];
    assign rd     = inst_id[11:7];
    assign rs1    = inst_id[19:15];
    assign rs2    = inst_id[24:20];

    always_comb begin
        use_rs1   = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        use_rs2   = (opcode == OP_RTYPE || opcode == OP_BRANCH || opcode == OP_STORE);
        writes_rd = !(opcode == OP_BRANCH || opcode == OP_STORE) && (rd != 5'd0);
        ctrl      = (opcode == OP_BRANCH || opcode == OP_JAL || opcode == OP_JALR);

        // A register being written back this cycle is already readable (RF bypass)
        busy_eff = busy_q;
        if (wb_we) busy_eff[wb_rd] = 1'b0;

        data_hazard = id_valid &&
                      ((use_rs1 && rs1 != 5'd0 && busy_eff[rs1]) ||
                       (use_rs2 && rs2 != 5'd0 && busy_eff[rs2]));

        issue     = 1'b0;
        stall_if  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        state_d   = state_q;

        if (state_q == ST_CWAIT) begin
            // A not-taken resolution still holds IF/ID so the fall-through issues next cycle
            bubble_ex = 1'b1;
            stall_if  = !(br_done && br_taken);
            flush_id  = br_done && br_taken;
            state_d   = br_done ? ST_RUN : ST_CWAIT;
        end else begin
            issue     = id_valid && !data_hazard;
            stall_if  = data_hazard;
            bubble_ex = data_hazard;
            if (issue && ctrl)     state_d = ST_CWAIT;
            else if (data_hazard)  state_d = ST_DSTALL;
            else                   state_d = ST_RUN;
        end

        // Set after clear so an issuing writer wins over a retiring one on the same register
        busy_d = busy_q;
        if (wb_we) busy_d[wb_rd] = 1'b0;
        if (issue && writes_rd) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

`ifdef PIPE_SCHED_PERF_EN
    logic [31:0] data_cnt_q, data_cnt_d;
    logic [31:0] ctrl_cnt_q, ctrl_cnt_d;

    always_comb begin
        data_cnt_d = data_cnt_q;
        ctrl_cnt_d = ctrl_cnt_q;
        if (state_q != ST_CWAIT && data_hazard) data_cnt_d = data_cnt_q + 32'd1;
        if (state_q == ST_CWAIT)                ctrl_cnt_d = ctrl_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_cnt_q <= 32'd0;
            ctrl_cnt_q <= 32'd0;
        end else begin
            data_cnt_q <= data_cnt_d;
            ctrl_cnt_q <= ctrl_cnt_d;
        end
    end

    assign stall_data_cnt = data_cnt_q;
    assign stall_ctrl_cnt = ctrl_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            busy_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    assign state    = state_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_pipe_sched.sv
module tb_pipe_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_id;
    logic        id_valid, wb_we, br_done, br_taken;
    logic [4:0]  wb_rd;
    logic        stall_if, bubble_ex, flush_id, issue;
    logic [1:0]  state;
    logic [31:0] busy_vec;
`ifdef PIPE_SCHED_PERF_EN
    logic [31:0] stall_data_cnt, stall_ctrl_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a set of pending registers, a mode number, stall tallies
    bit          pending [32];
    int          mode;
    int unsigned m_dcnt, m_ccnt;

    always #5 clk = ~clk;

    pipe_sched dut (
        .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .id_valid(id_valid),
        .wb_we(wb_we), .wb_rd(wb_rd), .br_done(br_done), .br_taken(br_taken),
        .stall_if(stall_if), .bubble_ex(bubble_ex), .flush_id(flush_id),
        .issue(issue), .state(state),
`ifdef PIPE_SCHED_PERF_EN
        .stall_data_cnt(stall_data_cnt), .stall_ctrl_cnt(stall_ctrl_cnt),
`endif
        .busy_vec(busy_vec)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd_,
                                       input logic [4:0] r1, input logic [4:0] r2);
        return {7'd0, r2, r1, 3'd0, rd_, opc};
    endfunction

    function automatic logic [31:0] pending_word();
        logic [31:0] w = '0;
        for (int i = 1; i < 32; i++) if (pending[i]) w[i] = 1'b1;
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pending[i] = 0;
        mode = 0; m_dcnt = 0; m_ccnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; id_valid = 0; wb_we = 0; br_done = 0; br_taken = 0;
        inst_id = 32'h0; wb_rd = 0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at negedge, compare just after, then advance the model on the edge
    task automatic step(input logic [31:0] ins, input bit idv, input bit we,
                        input logic [4:0] wrd, input bit bd, input bit bt);
        logic [6:0] opc;
        logic [4:0] d, s1, s2;
        bit u1, u2, wr, ctl, hz, e_issue, e_stall, e_bub, e_flush;
        bit eff [32];
        @(negedge clk);
        inst_id = ins; id_valid = idv; wb_we = we; wb_rd = wrd;
        br_done = bd; br_taken = bt;
        #1;
        opc = ins[6:0]; d = ins[11:7]; s1 = ins[19:15]; s2 = ins[24:20];
        u1  = !(opc inside {7'h37, 7'h17, 7'h6f});
        u2  = opc inside {7'h33, 7'h63, 7'h23};
        wr  = !(opc inside {7'h63, 7'h23}) && d != 0;
        ctl = opc inside {7'h63, 7'h6f, 7'h67};
        for (int i = 0; i < 32; i++) eff[i] = pending[i] && !(we && wrd == i);
        hz = idv && ((u1 && s1 != 0 && eff[s1]) || (u2 && s2 != 0 && eff[s2]));
        if (mode == 2) begin
            e_issue = 0; e_bub = 1; e_stall = !(bd && bt); e_flush = bd && bt;
        end else begin
            e_issue = idv && !hz; e_stall = hz; e_bub = hz; e_flush = 0;
        end
        chk_eq("state",     32'(state),     32'(mode));
        chk_eq("busy_vec",  busy_vec,       pending_word());
        chk_eq("issue",     32'(issue),     32'(e_issue));
        chk_eq("stall_if",  32'(stall_if),  32'(e_stall));
        chk_eq("bubble_ex", 32'(bubble_ex), 32'(e_bub));
        chk_eq("flush_id",  32'(flush_id),  32'(e_flush));
`ifdef PIPE_SCHED_PERF_EN
        chk_eq("data_cnt",  stall_data_cnt, m_dcnt);
        chk_eq("ctrl_cnt",  stall_ctrl_cnt, m_ccnt);
`endif
        @(posedge clk);
        if (mode == 2) begin
            m_ccnt++;
            mode = bd ? 0 : 2;
        end else begin
            if (hz) m_dcnt++;
            mode = (e_issue && ctl) ? 2 : (hz ? 1 : 0);
        end
        if (we) pending[wrd] = 0;
        if (e_issue && wr) pending[d] = 1;
        pending[0] = 0;
    endtask

    localparam logic [31:0] ADDI_X5 = 32'h00100293;  // addi x5,x0,1
    localparam logic [31:0] ADD_X6  = 32'h00528333;  // add  x6,x5,x5

    initial begin
        logic [6:0] pool [9];
        pool = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
        rst_n = 1'b0;
        do_reset();

        // Idle after reset
        for (int i = 0; i < 3; i++) step(32'h0, 0, 0, 0, 0, 0);

        // Producer/consumer with WB bypass
        step(ADDI_X5, 1, 0, 0, 0, 0);
        #1 chk_eq("busy_after_addi", busy_vec, 32'h20);
        step(ADD_X6, 1, 0, 0, 0, 0);
        #1 chk_eq("dstall_state", 32'(state), 32'd1);
        step(ADD_X6, 1, 0, 0, 0, 0);
        step(ADD_X6, 1, 1, 5'd5, 0, 0);
        #1 chk_eq("busy_after_bypass", busy_vec, 32'h40);

        // Same-cycle set and clear of x7
        step(mk(7'h13, 7, 0, 0), 1, 1, 5'd7, 0, 0);
        #1 chk_eq("set_wins_x7", 32'(busy_vec[7]), 32'd1);

        // Taken branch
        step(mk(7'h63, 0, 0, 0), 1, 0, 0, 0, 0);
        #1 chk_eq("cwait_state", 32'(state), 32'd2);
        step(32'h0, 1, 0, 0, 0, 0);
        step(32'h0, 1, 0, 0, 0, 0);
        step(32'h0, 1, 0, 0, 1, 1);
        #1 chk_eq("run_after_taken", 32'(state), 32'd0);

        // Not-taken branch: fall-through issues next cycle
        step(mk(7'h63, 0, 0, 0), 1, 0, 0, 0, 0);
        step(mk(7'h13, 1, 0, 0), 1, 0, 0, 1, 0);
        step(mk(7'h13, 1, 0, 0), 1, 0, 0, 0, 0);

        // Reset mid-CWAIT
        step(mk(7'h6f, 1, 0, 0), 1, 0, 0, 0, 0);
        step(32'h0, 0, 0, 0, 0, 0);
        do_reset();
        step(32'h0, 0, 0, 0, 0, 0);

        // Randomized traffic over x0..x7 for frequent hazards
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            bit bd;
            ins = mk(pool[$urandom_range(0, 8)], 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            bd = (mode == 2) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(ins, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 40,
                      5'($urandom_range(0, 7)), bd, $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
